// File: rtl/chdr_fifo_arbiter_pkg.sv
// Shared definitions for the CHDR FIFO arbiter: bus width, counter width, FSM state
// encoding and an index-width helper used to size port-select signals.
package chdr_fifo_arbiter_pkg;

  localparam int unsigned CHDR_W = 64;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [0:0] {
    StIdle,
    StPass
  } arb_state_e;

  // Width of an index able to address n items (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chdr_fifo_arbiter_rr_pick.sv
// Combinational round-robin priority pick.
// Searches last+1, last+2, ... (modulo NUM_PORTS) and returns the first requesting port.
// Ports:
//   req        in   NUM_PORTS   request vector
//   last       in   idx         most recently granted port
//   gnt_valid  out  1           at least one request present
//   gnt_idx    out  idx         winning port (0 when gnt_valid is low)
module chdr_fifo_arbiter_rr_pick
  import chdr_fifo_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [idx_w(NUM_PORTS)-1:0] last,
  output logic                        gnt_valid,
  output logic [idx_w(NUM_PORTS)-1:0] gnt_idx
);

  localparam int unsigned SrcW = idx_w(NUM_PORTS);

  int cand;

  // Walk offsets from farthest to nearest so the nearest requester after `last` wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int off = int'(NUM_PORTS); off >= 1; off--) begin
      cand = (int'(last) + off) % int'(NUM_PORTS);
      if (req[cand[SrcW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[SrcW-1:0];
      end
    end
  end

endmodule

// File: rtl/chdr_fifo_arbiter.sv
// Packet-granular round-robin arbiter feeding one shared CHDR FIFO from NUM_PORTS
// 64-bit AXI-Stream sources. A packet is admitted only when the FIFO has room for a
// max-size packet, so an admitted packet never stalls for lack of space.
// Optional per-port completed-packet counters: define CHDR_FIFO_ARB_STATS_EN.
// Ports:
//   clk, reset, clear      clock, sync active-high reset, sync soft clear (same effect)
//   i_tdata/tlast/tvalid   per-port input streams (port p data in [64p+63:64p])
//   i_tready               per-port ready; only the owning port sees o_tready
//   o_tdata/tlast/tvalid   stream to the shared FIFO; o_tready from the FIFO
//   o_src                  port owning the current packet
//   fifo_space             free words in the shared FIFO
//   o_pkt_cnt              per-port completed-packet counts, 32 bits each (0 when disabled)
module chdr_fifo_arbiter
  import chdr_fifo_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned SPACE_W   = 16,
  parameter int unsigned MTU_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [CHDR_W*NUM_PORTS-1:0]   i_tdata,
  input  logic [NUM_PORTS-1:0]          i_tlast,
  input  logic [NUM_PORTS-1:0]          i_tvalid,
  output logic [NUM_PORTS-1:0]          i_tready,
  output logic [CHDR_W-1:0]             o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready,
  output logic [idx_w(NUM_PORTS)-1:0]   o_src,
  input  logic [SPACE_W-1:0]            fifo_space,
  output logic [CNT_W*NUM_PORTS-1:0]    o_pkt_cnt
);

  localparam int unsigned SrcW = idx_w(NUM_PORTS);

  arb_state_e      state;
  logic [SrcW-1:0] last_grant;
  logic            gnt_valid;
  logic [SrcW-1:0] gnt_idx;
  logic            space_ok;
  logic            in_pass;
  logic            accept_last;

  assign space_ok    = (fifo_space >= SPACE_W'(MTU_WORDS));
  assign in_pass     = (state == StPass);
  assign accept_last = in_pass & o_tvalid & o_tready & o_tlast;

  chdr_fifo_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req       (i_tvalid),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // last_grant resets to the top port so port 0 is first in line.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= StIdle;
      last_grant <= SrcW'(NUM_PORTS - 1);
      o_src      <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (gnt_valid && space_ok) begin
            o_src      <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= StPass;
          end
        end
        StPass: begin
          if (accept_last) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Zero-latency pass-through from the owning port; everything gated off while idle.
  always_comb begin
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    i_tready = '0;
    if (in_pass) begin
      o_tdata         = i_tdata[int'(o_src)*CHDR_W +: CHDR_W];
      o_tlast         = i_tlast[o_src];
      o_tvalid        = i_tvalid[o_src];
      i_tready[o_src] = o_tready;
    end
  end

`ifdef CHDR_FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] pkt_cnt [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) pkt_cnt[p] <= '0;
    end else if (accept_last) begin
      pkt_cnt[o_src] <= pkt_cnt[o_src] + 1'b1;
    end
  end

  always_comb begin
    o_pkt_cnt = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) o_pkt_cnt[p*CNT_W +: CNT_W] = pkt_cnt[p];
  end
`else
  assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_chdr_fifo_arbiter.sv
// Directed bench for chdr_fifo_arbiter with a packet-level reference model and
// per-port source queues that honour the DUT's ready.
module tb_chdr_fifo_arbiter;

  localparam int N   = 4;
  localparam int MTU = 1024;
`ifdef CHDR_FIFO_ARB_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, clear;
  logic [64*N-1:0] i_tdata;
  logic [N-1:0]    i_tlast, i_tvalid, i_tready;
  logic [63:0]     o_tdata;
  logic            o_tlast, o_tvalid, o_tready;
  logic [1:0]      o_src;
  logic [15:0]     fifo_space;
  logic [32*N-1:0] o_pkt_cnt;

  chdr_fifo_arbiter #(
    .NUM_PORTS (N),
    .SPACE_W   (16),
    .MTU_WORDS (MTU)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .o_src      (o_src),
    .fifo_space (fifo_space),
    .o_pkt_cnt  (o_pkt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Source queues: bit 64 is tlast.
  logic [64:0] srcq [N][$];

  // Packet-level model: owner of the current packet (-1 when none), last grant, tag.
  int          m_owner = -1;
  int          m_last  = N - 1;
  int          m_src   = 0;
  int unsigned m_cnt [N];

  int          grants [$];
  logic [64:0] outq   [$];
  int          outcyc [$];
  int          cyc    = 0;
  bit          armed  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (srcq[p].size() > 0) begin
        i_tvalid[p]          = 1'b1;
        i_tdata[p*64 +: 64]  = srcq[p][0][63:0];
        i_tlast[p]           = srcq[p][0][64];
      end else begin
        i_tvalid[p]          = 1'b0;
        i_tdata[p*64 +: 64]  = '0;
        i_tlast[p]           = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int p, input int beats, input logic [31:0] tag);
    for (int b = 0; b < beats; b++) srcq[p].push_back({(b == beats - 1), tag, 32'(b)});
  endtask

  // One cycle: check at negedge, advance model, then pop/drive just after posedge.
  task automatic tick();
    logic [63:0]  e_data;
    logic         e_last, e_valid;
    logic [N-1:0] e_ready, hs;
    int           win;
    @(negedge clk);
    e_data = '0; e_last = 1'b0; e_valid = 1'b0; e_ready = '0;
    if (m_owner >= 0) begin
      e_data  = i_tdata[m_owner*64 +: 64];
      e_last  = i_tlast[m_owner];
      e_valid = i_tvalid[m_owner];
      e_ready = o_tready ? (N'(1) << m_owner) : '0;
    end
    if (armed) begin
      chk("o_tvalid", 64'(o_tvalid), 64'(e_valid));
      chk("o_tdata", o_tdata, e_data);
      chk("o_tlast", 64'(o_tlast), 64'(e_last));
      chk("i_tready", 64'(i_tready), 64'(e_ready));
      chk("o_src", 64'(o_src), 64'(m_src));
      for (int p = 0; p < N; p++)
        chk($sformatf("o_pkt_cnt[%0d]", p), 64'(o_pkt_cnt[p*32 +: 32]),
            StatsEn ? 64'(m_cnt[p]) : 64'd0);
    end
    hs = i_tvalid & i_tready;
    if (o_tvalid && o_tready) begin
      outq.push_back({o_tlast, o_tdata});
      outcyc.push_back(cyc);
    end
    if (reset || clear) begin
      m_owner = -1; m_last = N - 1; m_src = 0;
      for (int p = 0; p < N; p++) m_cnt[p] = 0;
    end else if (m_owner < 0) begin
      if (i_tvalid != '0 && fifo_space >= 16'(MTU)) begin
        win = -1;
        for (int off = 1; off <= N; off++)
          if (win < 0 && i_tvalid[(m_last + off) % N]) win = (m_last + off) % N;
        m_owner = win; m_last = win; m_src = win;
        grants.push_back(win);
      end
    end else if (i_tvalid[m_owner] && o_tready && i_tlast[m_owner]) begin
      m_cnt[m_owner]++;
      m_owner = -1;
    end
    @(posedge clk);
    #1;
    if (reset) armed = 1'b1;
    for (int p = 0; p < N; p++) if (hs[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
    drive();
    cyc++;
  endtask

  function automatic bit busy();
    bit b = (m_owner >= 0);
    for (int p = 0; p < N; p++) if (srcq[p].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int max_cyc);
    int n = 0;
    while (busy() && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n >= max_cyc), 64'd0);
  endtask

  int gb, ob, c0, n;

  initial begin
    reset = 1'b1; clear = 1'b0; o_tready = 1'b1; fifo_space = 16'd2000;
    for (int p = 0; p < N; p++) m_cnt[p] = 0;
    drive();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_src", 64'(o_src), 64'd0);
    chk("rst_tready", 64'(i_tready), 64'd0);
    chk("rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_tdata", o_tdata, 64'd0);

    // 1: port 2 sends 3 beats.
    gb = grants.size(); ob = outq.size();
    push_pkt(2, 3, 32'hA2);
    drive();
    c0 = cyc;
    drain(50);
    chk("t1_grant", 64'(grants[gb]), 64'd2);
    chk("t1_beats", 64'(outq.size() - ob), 64'd3);
    chk("t1_first_beat_cycle", 64'(outcyc[ob]), 64'(c0 + 1));
    chk("t1_beat0", 64'(outq[ob]), {1'b0, 64'h0000_00A2_0000_0000});
    chk("t1_beat2", 64'(outq[ob+2]), {1'b1, 64'h0000_00A2_0000_0002});

    // 2: all ports, two 2-beat packets each, from a fresh reset.
    reset = 1'b1; tick(); reset = 1'b0;
    gb = grants.size(); ob = outq.size();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < N; p++) push_pkt(p, 2, 32'(16 * p + k));
    drive();
    drain(100);
    chk("t2_g0", 64'(grants[gb]),   64'd0);
    chk("t2_g1", 64'(grants[gb+1]), 64'd1);
    chk("t2_g2", 64'(grants[gb+2]), 64'd2);
    chk("t2_g3", 64'(grants[gb+3]), 64'd3);
    chk("t2_g4", 64'(grants[gb+4]), 64'd0);
    chk("t2_beats", 64'(outq.size() - ob), 64'd16);
    for (int i = 1; i < 8; i++)
      chk($sformatf("t2_bubble%0d", i), 64'(outcyc[ob+2*i] - outcyc[ob+2*i-1]), 64'd2);

    // 3: admission threshold.
    fifo_space = 16'd1023;
    gb = grants.size();
    push_pkt(1, 2, 32'hB1);
    drive();
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("t3_no_grant", 64'(grants.size() - gb), 64'd0);
    chk("t3_tready", 64'(i_tready), 64'd0);
    fifo_space = 16'd1024;
    tick();
    #1;
    chk("t3_tvalid", 64'(o_tvalid), 64'd1);
    chk("t3_src", 64'(o_src), 64'd1);
    drain(50);
    fifo_space = 16'd2000;

    // 4: o_tready toggling across a 5-beat packet.
    ob = outq.size();
    push_pkt(0, 5, 32'hC0);
    drive();
    n = 0;
    while (busy() && n < 60) begin
      o_tready = (n % 2 == 0);
      tick();
      n++;
    end
    o_tready = 1'b1;
    chk("t4_timeout", 64'(n >= 60), 64'd0);
    chk("t4_beats", 64'(outq.size() - ob), 64'd5);
    for (int b = 0; b < 5; b++)
      chk($sformatf("t4_beat%0d", b), 64'(outq[ob+b]), {(b == 4), 32'hC0, 32'(b)});

    // 5: clear on beat 3 of 6; ports 0 and 3 wait behind port 1.
    gb = grants.size(); ob = outq.size();
    push_pkt(1, 6, 32'hD1);
    push_pkt(0, 1, 32'hD0);
    push_pkt(3, 1, 32'hD3);
    drive();
    n = 0;
    while (outq.size() - ob < 2 && n < 30) begin
      tick();
      n++;
    end
    chk("t5_timeout", 64'(n >= 30), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    srcq[1].delete();
    drive();
    #1;
    chk("t5_clr_tready", 64'(i_tready), 64'd0);
    chk("t5_clr_tvalid", 64'(o_tvalid), 64'd0);
    drain(50);
    chk("t5_g_first", 64'(grants[gb]),   64'd1);
    chk("t5_g_after", 64'(grants[gb+1]), 64'd0);
    chk("t5_g_next",  64'(grants[gb+2]), 64'd3);
    chk("t5_beats", 64'(outq.size() - ob), 64'd5);

    // 6: packet counters.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 10; k++) push_pkt(3, 2, 32'(k));
    drive();
    drain(200);
    #1;
    for (int p = 0; p < N; p++)
      chk($sformatf("t6_cnt%0d", p), 64'(o_pkt_cnt[p*32 +: 32]),
          (StatsEn && p == 3) ? 64'd10 : 64'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    #1;
    chk("t6_cleared", 64'(o_pkt_cnt != '0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
